// File: rtl/alu_operand_stage.sv
// Execute-stage operand selector: forwards rs1/rs2 from later pipeline
// stages, selects ALU operands A and B, and holds them in a valid/ready
// pipeline register with stall and flush.
module alu_operand_stage #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NUM_FWD = 2
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   input  logic [4:0]              rs1_idx,
   input  logic [4:0]              rs2_idx,
   input  logic [XLEN-1:0]         rs1_data,
   input  logic [XLEN-1:0]         rs2_data,
   input  logic [XLEN-1:0]         pc,
   input  logic [XLEN-1:0]         imm,
   input  logic [1:0]              a_sel,
   input  logic [1:0]              b_sel,
   input  logic [NUM_FWD-1:0]      fwd_valid,
   input  logic [5*NUM_FWD-1:0]    fwd_rd,
   input  logic [XLEN*NUM_FWD-1:0] fwd_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         alu_a,
   output logic [XLEN-1:0]         alu_b,
   output logic [XLEN-1:0]         store_data,
   output logic                    illegal_sel
);

   localparam logic [XLEN-1:0] CONST4 = XLEN'(4);

   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;
   logic [XLEN-1:0] sel_a;
   logic [XLEN-1:0] sel_b;
   logic            hit1;
   logic            hit2;
   logic            accept;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   // Forwarding: lowest-index matching source wins; x0 is never forwarded.
   always_comb begin
      fwd_rs1 = rs1_data;
      fwd_rs2 = rs2_data;
      hit1    = 1'b0;
      hit2    = 1'b0;
      for (int unsigned k = 0; k < NUM_FWD; k++) begin
         if (!hit1 && fwd_valid[k] && (fwd_rd[5*k +: 5] == rs1_idx) && (rs1_idx != 5'd0)) begin
            fwd_rs1 = fwd_data[XLEN*k +: XLEN];
            hit1    = 1'b1;
         end
         if (!hit2 && fwd_valid[k] && (fwd_rd[5*k +: 5] == rs2_idx) && (rs2_idx != 5'd0)) begin
            fwd_rs2 = fwd_data[XLEN*k +: XLEN];
            hit2    = 1'b1;
         end
      end
   end

   // Operand selection; a_sel==3 yields zero and is flagged separately.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      case (a_sel)
         2'd0:    sel_a = fwd_rs1;
         2'd1:    sel_a = pc;
         default: sel_a = '0;
      endcase
      case (b_sel)
         2'd0:    sel_b = fwd_rs2;
         2'd1:    sel_b = imm;
         2'd2:    sel_b = CONST4;
         default: sel_b = '0;
      endcase
   end

   // Pipeline register: reset, then flush, then accept, then drain on consume.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_valid   <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         store_data  <= '0;
         illegal_sel <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         alu_a       <= sel_a;
         alu_b       <= sel_b;
         store_data  <= fwd_rs2;
         illegal_sel <= (a_sel == 2'd3);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed cases with literal
// expectations, then randomized traffic against a queue-based reference.
module tb_alu_operand_stage;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned NUM_FWD = 2;

   logic                    clk = 1'b0;
   logic                    rstn;
   logic                    in_valid;
   logic                    in_ready;
   logic                    flush;
   logic [4:0]              rs1_idx;
   logic [4:0]              rs2_idx;
   logic [XLEN-1:0]         rs1_data;
   logic [XLEN-1:0]         rs2_data;
   logic [XLEN-1:0]         pc;
   logic [XLEN-1:0]         imm;
   logic [1:0]              a_sel;
   logic [1:0]              b_sel;
   logic [NUM_FWD-1:0]      fwd_valid;
   logic [5*NUM_FWD-1:0]    fwd_rd;
   logic [XLEN*NUM_FWD-1:0] fwd_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [XLEN-1:0]         alu_a;
   logic [XLEN-1:0]         alu_b;
   logic [XLEN-1:0]         store_data;
   logic                    illegal_sel;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
      logic        ill;
   } op_t;

   op_t held[$];
   op_t last;
   bit  known = 1'b0;

   alu_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
      .a_sel(a_sel), .b_sel(b_sel), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
      .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data),
      .illegal_sel(illegal_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   // Register value seen by an instruction: youngest pending write wins, x0 never.
   function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
      if (idx == 5'd0) return rf;
      for (int k = 0; k < int'(NUM_FWD); k++)
         if (fwd_valid[k] && fwd_rd[5*k +: 5] == idx) return fwd_data[32*k +: 32];
      return rf;
   endfunction

   function automatic op_t make_op();
      op_t o;
      logic [31:0] r1, r2;
      r1 = operand(rs1_idx, rs1_data);
      r2 = operand(rs2_idx, rs2_data);
      case (a_sel)
         2'd0: o.a = r1;
         2'd1: o.a = pc;
         default: o.a = 32'd0;
      endcase
      case (b_sel)
         2'd0: o.b = r2;
         2'd1: o.b = imm;
         2'd2: o.b = 32'd4;
         default: o.b = 32'd0;
      endcase
      o.sd  = r2;
      o.ill = (a_sel == 2'd3);
      return o;
   endfunction

   // Reference: at most one op held; ALU consumes, then a free slot takes a new op.
   always @(posedge clk) begin
      if (!rstn) begin
         held.delete();
         last  = '{32'd0, 32'd0, 32'd0, 1'b0};
         known = 1'b1;
      end else begin
         bit ready_now;
         ready_now = (held.size() == 0) || out_ready;
         if (held.size() > 0 && out_ready) void'(held.pop_front());
         if (flush) begin
            held.delete();
            known = 1'b0;
         end else if (in_valid && ready_now) begin
            last  = make_op();
            held.push_back(last);
            known = 1'b1;
         end
      end
   end

   // Compare DUT against the reference every cycle, away from the clock edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_out_valid", {31'd0, out_valid}, {31'd0, held.size() > 0});
         chk("m_in_ready", {31'd0, in_ready}, {31'd0, (held.size() == 0) || out_ready});
         if (known) begin
            chk("m_alu_a", alu_a, last.a);
            chk("m_alu_b", alu_b, last.b);
            chk("m_store_data", store_data, last.sd);
            chk("m_illegal", {31'd0, illegal_sel}, {31'd0, last.ill});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_inputs();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 15) == 0);
      rstn      = ($urandom_range(0, 99) != 0);
      rs1_idx   = 5'($urandom_range(0, 7));
      rs2_idx   = 5'($urandom_range(0, 7));
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      pc        = $urandom;
      imm       = $urandom;
      a_sel     = 2'($urandom_range(0, 3));
      b_sel     = 2'($urandom_range(0, 3));
      fwd_valid = 2'($urandom_range(0, 3));
      fwd_rd    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_data  = {$urandom, $urandom};
   endtask

   initial begin
      randomize_inputs();
      rstn = 1'b0; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;

      // Reset with in_valid asserted
      step();
      chk_en = 1'b1;
      step();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_illegal", {31'd0, illegal_sel}, 32'd0);

      // Select pc / const 4
      rstn = 1'b1; fwd_valid = 2'b00;
      a_sel = 2'd1; pc = 32'h100; b_sel = 2'd2;
      step();
      chk("sel_alu_a", alu_a, 32'h100);
      chk("sel_alu_b", alu_b, 32'd4);
      chk("sel_valid", {31'd0, out_valid}, 32'd1);

      // Forward priority: source 0 wins
      rs1_idx = 5'd5; fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5};
      fwd_data = {32'hBB, 32'hAA}; a_sel = 2'd0; rs1_data = 32'h777;
      step();
      chk("fwd_prio", alu_a, 32'hAA);
      rs1_idx = 5'd0;
      step();
      chk("fwd_x0", alu_a, 32'h777);

      // Stall: outputs frozen for 3 cycles
      fwd_valid = 2'b00; a_sel = 2'd1; pc = 32'h200; b_sel = 2'd1; imm = 32'h55;
      step();
      chk("stall_load", alu_a, 32'h200);
      for (int i = 0; i < 3; i++) begin
         out_ready = 1'b0; pc = $urandom; imm = $urandom; rs1_data = $urandom;
         step();
         chk("stall_a", alu_a, 32'h200);
         chk("stall_b", alu_b, 32'h55);
         chk("stall_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1; pc = 32'h300;
      #1;
      chk("unstall_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("unstall_a", alu_a, 32'h300);
      chk("unstall_valid", {31'd0, out_valid}, 32'd1);

      // Flush during stall
      out_ready = 1'b0;
      step();
      flush = 1'b1; in_valid = 1'b1;
      step();
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_ready", {31'd0, in_ready}, 32'd1);
      flush = 1'b0;

      // Illegal a_sel
      out_ready = 1'b1; a_sel = 2'd3; rs1_data = 32'h1234; b_sel = 2'd3;
      step();
      chk("ill_a", alu_a, 32'd0);
      chk("ill_flag", {31'd0, illegal_sel}, 32'd1);
      chk("ill_valid", {31'd0, out_valid}, 32'd1);

      // Back-to-back, one op per cycle
      a_sel = 2'd1;
      for (int i = 1; i <= 4; i++) begin
         pc = 32'(i) * 32'h10;
         step();
         chk("b2b_a", alu_a, 32'(i) * 32'h10);
         chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      end

      // Randomized traffic checked by the reference model
      for (int i = 0; i < 3000; i++) begin
         randomize_inputs();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
